// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr: N-port round-robin arbiter in front of one simple-dual-port RAM.
// The read and write channels are arbitrated independently. RAM-side outputs are
// registered, and read data is steered back to its requester by a one-hot tag
// pipeline whose depth matches the RAM read latency.
// Optional feature macro: ARB_DMA_PRIORITY_EN gives port 0 (DMA) strict priority
// on both channels; ports 1..N_PORTS-1 keep round-robin among themselves.
module ram_arbiter_rr #(
    parameter int W_ADDR     = 12,
    parameter int W_DATA     = 128,
    parameter int N_PORTS    = 4,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_rd_en,
    input  logic [N_PORTS*W_ADDR-1:0]   req_rd_addr,
    output logic [N_PORTS-1:0]          req_rd_gnt,
    output logic [N_PORTS-1:0]          req_rd_valid,
    output logic [W_DATA-1:0]           req_rd_data,
    input  logic [N_PORTS-1:0]          req_wr_en,
    input  logic [N_PORTS*W_ADDR-1:0]   req_wr_addr,
    input  logic [N_PORTS*W_DATA-1:0]   req_wr_data,
    output logic [N_PORTS-1:0]          req_wr_gnt,
    output logic                        ram_rd_en,
    output logic [W_ADDR-1:0]           ram_rd_addr,
    input  logic [W_DATA-1:0]           ram_rd_data,
    output logic                        ram_wr_en,
    output logic [W_ADDR-1:0]           ram_wr_addr,
    output logic [W_DATA-1:0]           ram_wr_data,
    output logic                        dma_active
);

    localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH = 1 + RAM_RD_LAT;
    localparam logic [N_PORTS-1:0] PORT0 = N_PORTS'(1);

    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [N_PORTS-1:0] rd_gnt;
    logic [N_PORTS-1:0] wr_gnt;
    logic [W_ADDR-1:0]  rd_addr_sel;
    logic [W_ADDR-1:0]  wr_addr_sel;
    logic [W_DATA-1:0]  wr_data_sel;
    logic [N_PORTS-1:0] tag_pipe [DEPTH];

    // First requester at or after ptr, wrapping: one pass over [ptr, N), then
    // a second pass from 0 that only matters if the first found nothing.
    function automatic logic [N_PORTS-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                                   input logic [PW-1:0]      ptr);
        logic [N_PORTS-1:0] g;
        logic               found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && req[k] && (PW'(k) >= ptr)) begin
                g[k]  = 1'b1;
                found = 1'b1;
            end
        end
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && req[k]) begin
                g[k]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [N_PORTS-1:0] arbitrate(input logic [N_PORTS-1:0] req,
                                                     input logic [PW-1:0]      ptr);
`ifdef ARB_DMA_PRIORITY_EN
        if (req[0]) begin
            return PORT0;
        end
        return rr_pick(req & ~PORT0, ptr);
`else
        return rr_pick(req, ptr);
`endif
    endfunction

    // Pointer moves just past the winner; no grant leaves it where it was.
    function automatic logic [PW-1:0] next_ptr(input logic [N_PORTS-1:0] g,
                                               input logic [PW-1:0]      ptr);
        logic [PW-1:0] n;
        n = ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            if (g[k]) begin
                n = (k == N_PORTS - 1) ? '0 : PW'(k + 1);
            end
        end
`ifdef ARB_DMA_PRIORITY_EN
        // A priority grant to DMA must not disturb the rotation among 1..N-1.
        if (g[0]) begin
            n = ptr;
        end
`endif
        return n;
    endfunction

    // Combinational grants, forced low while reset is asserted.
    always_comb begin
        rd_gnt = rst ? '0 : arbitrate(req_rd_en, rd_ptr);
        wr_gnt = rst ? '0 : arbitrate(req_wr_en, wr_ptr);
    end

    assign req_rd_gnt = rd_gnt;
    assign req_wr_gnt = wr_gnt;

    // Select the granted port's address/data for each channel.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise the tool infers a latch.
        rd_addr_sel = '0;
        wr_addr_sel = '0;
        wr_data_sel = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (rd_gnt[k]) begin
                rd_addr_sel = req_rd_addr[k*W_ADDR +: W_ADDR];
            end
            if (wr_gnt[k]) begin
                wr_addr_sel = req_wr_addr[k*W_ADDR +: W_ADDR];
                wr_data_sel = req_wr_data[k*W_DATA +: W_DATA];
            end
        end
    end

    // Round-robin pointers for both channels.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            rd_ptr <= next_ptr(rd_gnt, rd_ptr);
            wr_ptr <= next_ptr(wr_gnt, wr_ptr);
        end
    end

    // Registered RAM write port; address/data hold between transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            ram_wr_en <= |wr_gnt;
            if (|wr_gnt) begin
                ram_wr_addr <= wr_addr_sel;
                ram_wr_data <= wr_data_sel;
            end
        end
    end

    // Registered RAM read port; address holds between transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
        end else begin
            ram_rd_en <= |rd_gnt;
            if (|rd_gnt) begin
                ram_rd_addr <= rd_addr_sel;
            end
        end
    end

    // One-hot owner tag travels alongside the read for 1+RAM_RD_LAT cycles.
    always_ff @(posedge clk) begin
        // NOTE: this small tag array is reset, unlike a data RAM, because a stale
        // tag would raise req_rd_valid for a read that was aborted by reset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= rd_gnt;
            for (int i = 1; i < DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign req_rd_valid = tag_pipe[DEPTH-1];
    assign req_rd_data  = ram_rd_data;

    // DMA activity flag: port 0 holds a grant on either channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_active <= 1'b0;
        end else begin
            dma_active <= rd_gnt[0] | wr_gnt[0];
        end
    end

endmodule
